// File: rtl/kyber_decrypt_seq_if.sv
// Request (start/busy + key/ciphertext) and result (valid/ready + message) bundle of kyber_decrypt_seq.
// The mn_out debug bus exists only when DECRYPT_MN_DEBUG_EN is defined.
interface kyber_decrypt_seq_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 2,
    parameter int unsigned Q  = 17,
    parameter int unsigned CW = 32
);
    localparam int unsigned QW = $clog2(Q);

    logic                start;
    logic                busy;
    logic [K*N*CW-1:0]   secret_key;
    logic [K*N*CW-1:0]   ct_u;
    logic [N*CW-1:0]     ct_v;
    logic                valid;
    logic                ready;
    logic [N-1:0]        m_b;
    logic [N-1:0]        decimal_value;
`ifdef DECRYPT_MN_DEBUG_EN
    logic [N*QW-1:0]     mn_out;

    modport master (
        output start, secret_key, ct_u, ct_v, ready,
        input  busy, valid, m_b, decimal_value, mn_out
    );
    modport slave (
        input  start, secret_key, ct_u, ct_v, ready,
        output busy, valid, m_b, decimal_value, mn_out
    );
`else
    modport master (
        output start, secret_key, ct_u, ct_v, ready,
        input  busy, valid, m_b, decimal_value
    );
    modport slave (
        input  start, secret_key, ct_u, ct_v, ready,
        output busy, valid, m_b, decimal_value
    );
`endif
endinterface

// File: rtl/kyber_decrypt_seq.sv
// Sequential Baby Kyber decryption: mn = v - sum_k s_k*u_k in Z_q[x]/(x^N+1) with one shared MAC, then 1-bit decode.
// Define DECRYPT_MN_DEBUG_EN to expose the registered mn coefficients on mn_out.
module kyber_decrypt_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 2,
    parameter int unsigned Q  = 17,
    parameter int unsigned CW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    kyber_decrypt_seq_if.slave dec_if
);
    localparam int unsigned QW = $clog2(Q);
    localparam int unsigned NW = $clog2(N);
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [QW:0]          QV      = (QW+1)'(Q);
    localparam logic [2*QW-1:0]      QP      = (2*QW)'(Q);
    localparam logic signed [CW:0]   QS      = (CW+1)'(Q);
    localparam logic [QW:0]          BAND_LO = (QW+1)'(Q/4 + 1);
    localparam logic [QW:0]          BAND_HI = (QW+1)'(Q - Q/4);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [K*N*CW-1:0]   sk_raw_q, sk_raw_d, u_raw_q, u_raw_d;
    logic [N*CW-1:0]     v_raw_q, v_raw_d;
    logic [QW-1:0]       s_q [K][N];
    logic [QW-1:0]       s_d [K][N];
    logic [QW-1:0]       u_q [K][N];
    logic [QW-1:0]       u_d [K][N];
    logic [QW-1:0]       v_q [N];
    logic [QW-1:0]       v_d [N];
    logic [QW-1:0]       acc_q [N];
    logic [QW-1:0]       acc_d [N];
    logic [KW-1:0]       k_q, k_d;
    logic [NW-1:0]       i_q, i_d, j_q, j_d;
    logic                busy_q, busy_d, valid_q, valid_d;
    logic [N-1:0]        m_b_q, m_b_d, dec_q, dec_d;
`ifdef DECRYPT_MN_DEBUG_EN
    logic [N*QW-1:0]     mn_q, mn_d;
`endif

    logic [2*QW-1:0]     prod_c;
    logic [QW-1:0]       p_c;
    logic [NW:0]         ij_c;
    logic [NW-1:0]       t_c;
    logic [QW:0]         sum_c;
    logic [QW-1:0]       acc_new_c;
    logic [QW:0]         diff_c [N];

    // True modulo of a signed coefficient into [0,Q-1].
    function automatic logic [QW-1:0] mod_q(input logic [CW-1:0] x);
        logic signed [CW:0] r;
        r = $signed({x[CW-1], x}) % QS;
        if (r < 0) r = r + QS;
        return QW'(r);
    endfunction

    // Shared MAC: product mod Q, then add or (negacyclic wrap) subtract into acc[t].
    always_comb begin
        prod_c = (2*QW)'(s_q[k_q][i_q]) * (2*QW)'(u_q[k_q][j_q]);
        p_c    = QW'(prod_c % QP);
        ij_c   = (NW+1)'(i_q) + (NW+1)'(j_q);
        t_c    = ij_c[NW-1:0];
        sum_c  = '0;
        if (!ij_c[NW]) begin
            sum_c = (QW+1)'(acc_q[t_c]) + (QW+1)'(p_c);
            if (sum_c >= QV) sum_c = sum_c - QV;
        end else if (acc_q[t_c] >= p_c) begin
            sum_c = (QW+1)'(acc_q[t_c]) - (QW+1)'(p_c);
        end else begin
            sum_c = (QW+1)'(acc_q[t_c]) + QV - (QW+1)'(p_c);
        end
        acc_new_c = sum_c[QW-1:0];
    end

    // mn[n] = (v[n] - acc[n]) mod Q
    always_comb begin
        for (int n = 0; n < N; n++) begin
            if (v_q[n] >= acc_q[n]) diff_c[n] = (QW+1)'(v_q[n]) - (QW+1)'(acc_q[n]);
            else                    diff_c[n] = (QW+1)'(v_q[n]) + QV - (QW+1)'(acc_q[n]);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        sk_raw_d = sk_raw_q;
        u_raw_d  = u_raw_q;
        v_raw_d  = v_raw_q;
        s_d      = s_q;
        u_d      = u_q;
        v_d      = v_q;
        acc_d    = acc_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        m_b_d    = m_b_q;
        dec_d    = dec_q;
`ifdef DECRYPT_MN_DEBUG_EN
        mn_d     = mn_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dec_if.start) begin
                    sk_raw_d = dec_if.secret_key;
                    u_raw_d  = dec_if.ct_u;
                    v_raw_d  = dec_if.ct_v;
                    busy_d   = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int k = 0; k < K; k++) begin
                    for (int n = 0; n < N; n++) begin
                        s_d[k][n] = mod_q(sk_raw_q[(k*N+n)*CW +: CW]);
                        u_d[k][n] = mod_q(u_raw_q[(k*N+n)*CW +: CW]);
                    end
                end
                for (int n = 0; n < N; n++) begin
                    v_d[n]   = mod_q(v_raw_q[n*CW +: CW]);
                    acc_d[n] = '0;
                end
                k_d     = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d[t_c] = acc_new_c;
                j_d        = j_q + NW'(1);
                if (j_q == NW'(N-1)) begin
                    j_d = '0;
                    i_d = i_q + NW'(1);
                    if (i_q == NW'(N-1)) begin
                        i_d = '0;
                        if (k_q == KW'(K-1)) state_d = S_FINAL;
                        else                 k_d     = k_q + KW'(1);
                    end
                end
            end
            S_FINAL: begin
                for (int n = 0; n < N; n++) begin
                    m_b_d[n]       = (diff_c[n] >= BAND_LO) && (diff_c[n] <= BAND_HI);
                    dec_d[N-1-n]   = (diff_c[n] >= BAND_LO) && (diff_c[n] <= BAND_HI);
`ifdef DECRYPT_MN_DEBUG_EN
                    mn_d[n*QW +: QW] = diff_c[n][QW-1:0];
`endif
                end
                busy_d  = 1'b0;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (dec_if.ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sk_raw_q <= '0;
            u_raw_q  <= '0;
            v_raw_q  <= '0;
            for (int k = 0; k < K; k++) begin
                for (int n = 0; n < N; n++) begin
                    s_q[k][n] <= '0;
                    u_q[k][n] <= '0;
                end
            end
            for (int n = 0; n < N; n++) begin
                v_q[n]   <= '0;
                acc_q[n] <= '0;
            end
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            m_b_q    <= '0;
            dec_q    <= '0;
`ifdef DECRYPT_MN_DEBUG_EN
            mn_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sk_raw_q <= sk_raw_d;
            u_raw_q  <= u_raw_d;
            v_raw_q  <= v_raw_d;
            s_q      <= s_d;
            u_q      <= u_d;
            v_q      <= v_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            m_b_q    <= m_b_d;
            dec_q    <= dec_d;
`ifdef DECRYPT_MN_DEBUG_EN
            mn_q     <= mn_d;
`endif
        end
    end

    assign dec_if.busy          = busy_q;
    assign dec_if.valid         = valid_q;
    assign dec_if.m_b           = m_b_q;
    assign dec_if.decimal_value = dec_q;
`ifdef DECRYPT_MN_DEBUG_EN
    assign dec_if.mn_out        = mn_q;
`endif

endmodule
